// File: rtl/datapath_trace_buffer.sv
// datapath_trace_buffer
// Execution-trace capture unit for the datapath core. Records (pc, result)
// retire samples into a DEPTH-entry buffer. Capture starts at once or on a
// pc match. The buffer either stops when full or overwrites the oldest entry.
// Captured entries drain oldest-first through a valid/ready read port. Reads
// are accepted in every state, including while capture is still running.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   arm                   pulse: clear buffer, latch mode, enter ARMED
//   stop                  pulse: end capture (ARMED/CAPTURE -> DONE)
//   mode                  0 = stop when full, 1 = circular overwrite
//   trig_en, trig_pc      wait for pc_in == trig_pc before capturing
//   sample_valid          pc_in/result_in carry a retired instruction
//   pc_in, result_in      datapath sample
//   rd_valid, rd_ready    read handshake for the head (oldest) entry
//   rd_pc, rd_result      head entry contents
//   count                 occupancy, 0..DEPTH
//   overflow              sticky: an entry was overwritten in circular mode
//   state                 IDLE=0, ARMED=1, CAPTURE=2, DONE=3
module datapath_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              stop,
    input  logic              mode,
    input  logic              trig_en,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic              sample_valid,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] result_in,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PC_W-1:0]   rd_pc,
    output logic [DATA_W-1:0] rd_result,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [1:0]        state
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;
    logic                   r_mode;
    logic [PC_W+DATA_W-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_read;
    logic w_trigHit;
    logic w_write;
    logic w_overwrite;
    logic w_fillsUp;

    // Handshake and write qualification. arm suppresses both the read and
    // the write of its cycle. A stop-mode buffer that is full accepts no
    // further writes. A full circular buffer overwrites only when no read
    // frees a slot on the same edge.
    always_comb begin
        w_full      = (r_count == CNT_W'(DEPTH));
        w_read      = !arm && (r_count != '0) && rd_ready;
        w_trigHit   = sample_valid && (!trig_en || (pc_in == trig_pc));
        w_write     = !arm
                      && (((r_state == ARMED) && w_trigHit)
                          || ((r_state == CAPTURE) && sample_valid))
                      && (r_mode || !w_full || w_read);
        w_overwrite = w_write && w_full && !w_read;
        w_fillsUp   = w_write && !r_mode && !w_read
                      && (r_count == CNT_W'(DEPTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. The triggering sample itself is captured, so the
    // write that leaves ARMED can also be the one that fills the buffer.
    always_comb begin
        w_stateNext = r_state;
        if (arm) begin
            w_stateNext = ARMED;
        end else begin
            case (r_state)
                ARMED: begin
                    if (stop || w_fillsUp) begin
                        w_stateNext = DONE;
                    end else if (w_write) begin
                        w_stateNext = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop || w_fillsUp) begin
                        w_stateNext = DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointers, occupancy and sticky overflow. The read pointer also moves
    // on an overwrite so the head is always the oldest surviving entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_mode     <= 1'b0;
        end else if (arm) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_mode     <= mode;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_read || w_overwrite) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_write && !w_overwrite && !w_read) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_read && !w_write) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_overwrite) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Sample storage. It has no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= {pc_in, result_in};
        end
    end

    // Output decode, all from registered state.
    always_comb begin
        rd_valid             = (r_count != '0);
        {rd_pc, rd_result}   = r_mem[r_rdPtr];
        count                = r_count;
        overflow             = r_overflow;
        state                = r_state;
    end

endmodule

// File: doc/datapath_trace_buffer.md
Name: datapath_trace_buffer

Overview:
Parametrised, synthesizable execution-trace capture unit attached to the datapath core's pc/result outputs. It is the on-chip successor to the per-clock pc/result console monitor. It records (pc, result) samples into a DEPTH-entry buffer after an optional pc-match trigger. Two capture modes: stop-when-full or circular overwrite. Captured samples drain oldest-first over a valid/ready read port.

Parameters:
DATA_W, 32, width of the result sample
PC_W, 8, width of the pc sample
DEPTH, 16, buffer entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
arm  input  1  one-cycle pulse: clear buffer and enter ARMED
stop  input  1  one-cycle pulse: end capture (CAPTURE -> DONE)
mode  input  1  0 = stop-when-full, 1 = circular overwrite; sampled on arm
trig_en  input  1  1 = wait for pc match; 0 = start capture immediately
trig_pc  input  PC_W  trigger pc value
sample_valid  input  1  pc_in/result_in valid this cycle (datapath retire strobe)
pc_in  input  PC_W  datapath pc
result_in  input  DATA_W  datapath result
rd_valid  output  1  buffer non-empty
rd_ready  input  1  consumer accepts the head entry
rd_pc  output  PC_W  head-entry pc
rd_result  output  DATA_W  head-entry result
count  output  CNT_W  current occupancy, 0..DEPTH
overflow  output  1  sticky: at least one entry overwritten (circular mode)
state  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, pointers=0, overflow=0, rd_valid=0, mode latch=0. rd_pc/rd_result are don't-care while rd_valid=0 (bench checks them only when rd_valid=1). Buffer storage is not cleared. Reset asserted mid-capture takes effect immediately, independent of clk.
- arm (any state): next cycle state=ARMED; pointers, count and overflow cleared; mode latched. arm wins over a same-cycle write, read or stop; that read is not a transfer.
- ARMED: on a cycle with sample_valid=1 and (trig_en=0 or pc_in==trig_pc):
  - that sample is written;
  - state -> CAPTURE.
  Non-matching samples are discarded.
- CAPTURE: every sample_valid=1 cycle writes {pc_in, result_in} at wr_ptr; wr_ptr increments modulo DEPTH.
- Write latency: a sample written on edge N is visible at rd_* / count after edge N (same-cycle read of an empty buffer is not bypassed).
- Stop mode (mode=0):
  - the write that makes count==DEPTH moves state -> DONE on the same edge;
  - no further writes occur.
- Circular mode (mode=1):
  - a write with count==DEPTH and no same-cycle read overwrites the oldest entry;
  - rd_ptr advances, count stays DEPTH, overflow set (sticky until arm or reset).
- stop in ARMED or CAPTURE: state -> DONE. A sample on the same cycle as stop is still written if it otherwise would be. stop in IDLE/DONE is ignored.
- Read handshake:
  - rd_valid = (count!=0), combinational from registered state;
  - rd_pc/rd_result = entry at rd_ptr;
  - transfer when rd_valid & rd_ready: rd_ptr++ mod DEPTH, count--.
  - Reads are allowed in every state, including during capture.
  - rd_ready with rd_valid=0 has no effect.
- Simultaneous write and read transfer: count unchanged, both pointers advance. When full in circular mode this is not an overflow.
- DONE holds until arm. Writes are ignored, reads continue.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count disambiguates full from empty.

Test Plan:
- Reset: pulse rst_n low mid-CAPTURE with count=3 -> immediately state=0, count=0, rd_valid=0, overflow=0 (no clock edge needed).
- Stop mode, DEPTH=4, trig_en=0, arm, then samples pc=0..5 with result=3*pc -> state=DONE after pc=3, count=4; drain yields (0,0),(1,3),(2,6),(3,9), then rd_valid=0.
- Trigger: trig_en=1, trig_pc=5, samples pc=1..10 -> state stays ARMED through pc=4, enters CAPTURE on pc=5; first read entry pc=5.
- Circular, DEPTH=4, pcs 0..9 then stop -> count=4, overflow=1, drain yields pcs 6,7,8,9 in order.
- Circular full (count=4), sample_valid=1 and rd_ready=1 for 3 cycles -> count stays 4, overflow stays 0, reads return oldest entries in order.
- arm asserted with rd_ready=1 and count=2 -> no transfer; next cycle count=0, state=ARMED, overflow=0.
